// File: rtl/ws2812_pkg.sv
// Shared types and helpers for the WS2812 frame feeder: FSM states, GRB packing,
// latch-gap derivation.
package ws2812_pkg;

    localparam int unsigned CH_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        LATCH
    } state_t;

    function automatic int latch_cycles(input int clk_hz, input int latch_us);
        return clk_hz / 1_000_000 * latch_us;
    endfunction

    function automatic logic [3*CH_W-1:0] grb_pack(input logic [CH_W-1:0] r,
                                                   input logic [CH_W-1:0] g,
                                                   input logic [CH_W-1:0] b);
        return {g, r, b};
    endfunction

endpackage

// File: rtl/ws2812_scale.sv
// One colour channel scaled by global brightness: (c * (brightness + 1)) >> 8.
module ws2812_scale
    import ws2812_pkg::*;
(
    input  logic [CH_W-1:0] c,
    input  logic [CH_W-1:0] brightness,
    output logic [CH_W-1:0] scaled
);

    logic [2*CH_W-1:0] prod;

    // brightness+1 peaks at 256, so 255*256 still fits the 16-bit product
    always_comb begin
        prod   = {{CH_W{1'b0}}, c} * ({{CH_W{1'b0}}, brightness} + (2*CH_W)'(1));
        scaled = CH_W'(prod >> CH_W);
    end

endmodule

// File: rtl/ws2812_frame_feeder.sv
// Frame buffer plus pixel sequencer feeding the WS2812 RZ encoder, with per-pixel
// timeout and a latch gap after the last pixel.
module ws2812_frame_feeder
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS    = 8,
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int LATCH_US    = 300,
    parameter int TX_TIMEOUT  = 4096,
    localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [3*CH_W-1:0] wr_rgb,
    input  logic [CH_W-1:0]   brightness,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic              err,
    output logic              data_ready,
    output logic              data_valid,
    output logic [3*CH_W-1:0] RGB,
    input  logic              tx_done
);

    localparam int LATCH_CYCLES = latch_cycles(CLK_FREQ_HZ, LATCH_US);
    localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam int TW = $clog2(TX_TIMEOUT + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_LEDS - 1);

    state_t            state, state_nxt;
    logic [3*CH_W-1:0] mem [NUM_LEDS];
    logic [3*CH_W-1:0] pix;
    logic [AW-1:0]     idx;
    logic [CH_W-1:0]   bright;
    logic [LW-1:0]     latch_cnt;
    logic [TW-1:0]     tout_cnt;
    logic [CH_W-1:0]   r_s, g_s, b_s;
    logic              is_last, accept, advance, timed_out, latch_end;

    always_comb begin
        pix     = mem[idx];
        is_last = (idx == LAST_IDX);
    end

    ws2812_scale u_scale_r (.c(pix[23:16]), .brightness(bright), .scaled(r_s));
    ws2812_scale u_scale_g (.c(pix[15:8]),  .brightness(bright), .scaled(g_s));
    ws2812_scale u_scale_b (.c(pix[7:0]),   .brightness(bright), .scaled(b_s));

    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (wr_en && (int'(wr_addr) < NUM_LEDS)) begin
            mem[wr_addr] <= wr_rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        advance    = 1'b0;
        timed_out  = 1'b0;
        latch_end  = 1'b0;
        busy       = (state != IDLE);
        data_ready = (state == SEND);
        data_valid = (state == SEND) && is_last;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = SEND;
            SEND: begin
                if (tx_done) begin
                    if (is_last) begin
                        state_nxt = LATCH;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = LOAD;
                    end
                end else if (tout_cnt == TW'(TX_TIMEOUT)) begin
                    timed_out = 1'b1;
                    state_nxt = LATCH;
                end
            end
            LATCH: begin
                if (latch_cnt == LW'(LATCH_CYCLES - 1)) begin
                    latch_end = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters free-run only inside their own state, so entry always starts from zero
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            bright     <= '0;
            err        <= 1'b0;
            frame_done <= 1'b0;
            RGB        <= '0;
            latch_cnt  <= '0;
            tout_cnt   <= '0;
        end else begin
            frame_done <= latch_end;
            latch_cnt  <= (state == LATCH) ? latch_cnt + LW'(1) : '0;
            tout_cnt   <= (state == SEND)  ? tout_cnt + TW'(1)  : '0;
            if (accept) begin
                idx    <= '0;
                bright <= brightness;
                err    <= 1'b0;
            end
            if (advance) begin
                idx <= idx + AW'(1);
            end
            if (timed_out) begin
                err <= 1'b1;
            end
            if (state == LOAD) begin
                RGB <= grb_pack(r_s, g_s, b_s);
            end
        end
    end

endmodule

// File: tb/tb_ws2812_frame_feeder.sv
// Scenario bench for ws2812_frame_feeder with a behavioural encoder and a pixel scoreboard.
module tb_ws2812_frame_feeder;

    localparam int NUM    = 3;
    localparam int CLK_HZ = 1_000_000;
    localparam int LAT_US = 20;
    localparam int LAT    = CLK_HZ / 1_000_000 * LAT_US;
    localparam int TOUT   = 64;
    localparam int RESP   = 30;

    typedef struct {
        logic [23:0] rgb;
        logic        valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, wr_en, start, tx_done;
    logic [1:0]  wr_addr;
    logic [23:0] wr_rgb;
    logic [7:0]  brightness;
    logic        busy, frame_done, err, data_ready, data_valid;
    logic [23:0] RGB;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] bufm [NUM];
    exp_t        exp_q [$];

    always #5 clk = ~clk;

    ws2812_frame_feeder #(
        .NUM_LEDS   (NUM),
        .CLK_FREQ_HZ(CLK_HZ),
        .LATCH_US   (LAT_US),
        .TX_TIMEOUT (TOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_rgb    (wr_rgb),
        .brightness(brightness),
        .start     (start),
        .busy      (busy),
        .frame_done(frame_done),
        .err       (err),
        .data_ready(data_ready),
        .data_valid(data_valid),
        .RGB       (RGB),
        .tx_done   (tx_done)
    );

    function automatic logic [7:0] sc(input logic [7:0] c, input logic [7:0] b);
        int p;
        p = int'(c) * (int'(b) + 1);
        return 8'(p / 256);
    endfunction

    task automatic write_px(input logic [1:0] addr, input logic [23:0] val);
        wr_en = 1'b1; wr_addr = addr; wr_rgb = val;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (int'(addr) < NUM) bufm[addr] = val;
    endtask

    task automatic run_frame(input logic [7:0] br, input bit respond, input bit inject);
        exp_t        e;
        int          cyc, rise_cyc, tx_cyc, last_tx, rise0, pixels, npix, unstable, latch_bad, exp_done;
        bit          prev_rdy, answered, done_seen;
        logic [23:0] held_rgb;
        logic        held_valid;
        npix = respond ? NUM : 1;
        for (int i = 0; i < npix; i++) begin
            e.rgb   = {sc(bufm[i][15:8], br), sc(bufm[i][23:16], br), sc(bufm[i][7:0], br)};
            e.valid = (i == NUM - 1);
            exp_q.push_back(e);
        end
        cyc = 0; rise_cyc = 0; tx_cyc = -1; last_tx = -1; rise0 = -1; pixels = 0;
        unstable = 0; latch_bad = 0; exp_done = -1;
        prev_rdy = 0; answered = 0; done_seen = 0; held_rgb = '0; held_valid = 1'b0;
        brightness = br; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({busy, data_ready, err} !== 3'b100) begin
            errors++;
            $display("FAIL start_accept got busy/ready/err=%b exp 100", {busy, data_ready, err});
        end
        while (!done_seen && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++; tx_done = 1'b0; start = 1'b0;
            if (data_ready && !prev_rdy) begin
                pixels++; rise_cyc = cyc; answered = 0;
                if (rise0 < 0) rise0 = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_pixel got rgb=%h exp no pixel", RGB);
                end else begin
                    e = exp_q.pop_front();
                    if (RGB !== e.rgb || data_valid !== e.valid) begin
                        errors++;
                        $display("FAIL pixel%0d got rgb=%h valid=%b exp rgb=%h valid=%b",
                                 pixels - 1, RGB, data_valid, e.rgb, e.valid);
                    end
                end
                if (tx_cyc >= 0) begin
                    checks++;
                    if (cyc - tx_cyc != 2) begin
                        errors++;
                        $display("FAIL pixel_gap got %0d exp 2", cyc - tx_cyc);
                    end
                end
                held_rgb = RGB; held_valid = data_valid;
            end else if (data_ready && (RGB !== held_rgb || data_valid !== held_valid)) begin
                unstable++;
            end
            if (respond && data_ready && !answered && cyc - rise_cyc == RESP) begin
                tx_done = 1'b1; answered = 1; tx_cyc = cyc;
                if (data_valid) last_tx = cyc;
            end
            if (inject && pixels == 1 && cyc - rise_cyc == 5) start = 1'b1;
            if (last_tx >= 0 && cyc > last_tx && cyc <= last_tx + LAT && (data_ready || frame_done))
                latch_bad++;
            if (!respond && rise0 >= 0 && cyc == rise0 + TOUT) begin
                checks++;
                if (err !== 1'b0) begin
                    errors++;
                    $display("FAIL err_early got %b exp 0", err);
                end
            end
            if (!respond && rise0 >= 0 && cyc == rise0 + TOUT + 1) begin
                checks++;
                if (err !== 1'b1) begin
                    errors++;
                    $display("FAIL err_set got %b exp 1", err);
                end
            end
            if (frame_done) begin
                done_seen = 1;
                exp_done  = respond ? last_tx + LAT + 1 : rise0 + TOUT + LAT + 1;
                checks++;
                if (cyc != exp_done || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_done_time got cyc=%0d busy=%b exp cyc=%0d busy=0",
                             cyc, busy, exp_done);
                end
            end
            prev_rdy = data_ready;
        end
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL frame_done_bound got none in %0d cycles exp pulse", cyc);
        end
        checks++;
        if (pixels != npix || exp_q.size() != 0) begin
            errors++;
            $display("FAIL pixel_count got %0d exp %0d", pixels, npix);
        end
        exp_q.delete();
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL hold_stable got %0d changes exp 0", unstable);
        end
        checks++;
        if (latch_bad != 0) begin
            errors++;
            $display("FAIL latch_gap got %0d active cycles exp 0", latch_bad);
        end
        @(posedge clk); #1;
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_pulse got %b exp 0", frame_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, frame_done, err, data_ready, data_valid, RGB} !== 29'd0) begin
            errors++;
            $display("FAIL reset_state got %h exp 0", {busy, frame_done, err, data_ready, data_valid, RGB});
        end
        rst = 1'b0;
        for (int i = 0; i < NUM; i++) bufm[i] = '0;
    endtask

    task automatic test_basic();
        write_px(2'd0, 24'hFF0000);
        write_px(2'd1, 24'h00FF00);
        write_px(2'd2, 24'h0000FF);
        write_px(2'd3, 24'h123456);
        run_frame(8'd255, 1, 0);
    endtask

    task automatic test_brightness();
        run_frame(8'd127, 1, 0);
        run_frame(8'd0, 1, 0);
    endtask

    task automatic test_ignored();
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        checks++;
        if ({busy, data_ready} !== 2'b00) begin
            errors++;
            $display("FAIL idle_tx_done got busy/ready=%b exp 00", {busy, data_ready});
        end
        run_frame(8'd255, 1, 1);
    endtask

    task automatic test_timeout();
        run_frame(8'd255, 0, 0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b exp 1", err);
        end
    endtask

    task automatic test_err_clear();
        run_frame(8'd200, 1, 0);
    endtask

    task automatic test_reset_mid();
        int cyc, rise, pixels, fd;
        bit prev;
        cyc = 0; rise = 0; pixels = 0; fd = 0; prev = 0;
        brightness = 8'd255; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (pixels < 2 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++; tx_done = 1'b0;
            if (data_ready && !prev) begin pixels++; rise = cyc; end
            if (pixels == 1 && data_ready && cyc - rise == 10) tx_done = 1'b1;
            prev = data_ready;
        end
        tx_done = 1'b0;
        checks++;
        if (pixels != 2) begin
            errors++;
            $display("FAIL reach_pixel2 got %0d pixels exp 2", pixels);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({busy, frame_done, err, data_ready, data_valid, RGB} !== 29'd0) begin
            errors++;
            $display("FAIL mid_reset got %h exp 0", {busy, frame_done, err, data_ready, data_valid, RGB});
        end
        for (int i = 0; i < NUM; i++) bufm[i] = '0;
        repeat (LAT + 50) begin
            @(posedge clk); #1;
            if (frame_done || busy) fd++;
        end
        checks++;
        if (fd != 0) begin
            errors++;
            $display("FAIL no_frame_done got %0d active cycles exp 0", fd);
        end
        run_frame(8'd255, 1, 0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_rgb = '0;
        brightness = '0; start = 1'b0; tx_done = 1'b0;
        test_reset();
        test_basic();
        test_brightness();
        test_ignored();
        test_timeout();
        test_err_clear();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
